// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: state encoding, stall bit indices and request constants shared by the arbiter
package bus_arbiter_pkg;
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_BUS_IF   = 3'd1;
  localparam logic [2:0] S_BUS_MEM  = 3'd2;
  localparam logic [2:0] S_HOLD_IF  = 3'd3;
  localparam logic [2:0] S_HOLD_MEM = 3'd4;
  localparam int STALL_IF  = 1;
  localparam int STALL_MEM = 4;
  localparam logic ReqEnable  = 1'b1;
  localparam logic ReqDisable = 1'b0;
  function automatic logic is_bus(input logic [2:0] s);
    return (s == S_BUS_IF) || (s == S_BUS_MEM);
  endfunction
endpackage

// File: rtl/bus_timeout_cnt.sv
// bus_timeout_cnt: counts unacknowledged bus cycles; expired marks the cycle whose increment reaches MAX
module bus_timeout_cnt #(
  parameter int MAX = 255,
  parameter int W = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + W'(1);
  assign expired = en & (cnt == W'(MAX - 1));
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one memory bus between instruction fetch and MEM-stage loads/stores
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          stall,
  input  logic                flush,
  input  logic                if_ce,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  input  logic                mem_ce,
  input  logic                mem_we,
  input  logic [DATA_W/8-1:0] mem_sel,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_err,
  output logic                stallreq_from_if,
  output logic                stallreq_from_mem,
  output logic                bus_req,
  output logic                bus_we,
  output logic [DATA_W/8-1:0] bus_sel,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_ack
);
  logic [2:0] state, state_nx;
  logic discard, disc, expired, in_bus, done, start_if, start_mem, if_cap, mem_cap;
  logic [DATA_W-1:0] rd;
  logic unused;
  assign unused = ^{stall[5], stall[3:2], stall[0]};
  assign in_bus = is_bus(state);
  bus_timeout_cnt #(.MAX(TIMEOUT)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(state == S_IDLE),
    .en(in_bus & ~bus_ack),
    .expired(expired)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= state_nx;
  // A flushed fetch still finishes on the bus but never reaches HOLD_IF
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     state_nx = mem_ce ? S_BUS_MEM : (if_ce & ~flush) ? S_BUS_IF : S_IDLE;
      S_BUS_IF:   state_nx = (bus_ack | expired) ? (disc ? S_IDLE : S_HOLD_IF) : S_BUS_IF;
      S_BUS_MEM:  state_nx = (bus_ack | expired) ? S_HOLD_MEM : S_BUS_MEM;
      S_HOLD_IF:  state_nx = (flush | ~stall[STALL_IF]) ? S_IDLE : S_HOLD_IF;
      S_HOLD_MEM: state_nx = ~stall[STALL_MEM] ? S_IDLE : S_HOLD_MEM;
      default:    state_nx = S_IDLE;
    endcase
  end
  always_comb begin
    disc = discard | flush;
    done = in_bus & (bus_ack | expired);
    start_mem = (state == S_IDLE) & mem_ce;
    start_if = (state == S_IDLE) & ~mem_ce & if_ce & ~flush;
    if_cap = (state == S_BUS_IF) & done & ~disc;
    mem_cap = (state == S_BUS_MEM) & done;
    rd = (expired | bus_we) ? '0 : bus_rdata;
    stallreq_from_if = if_ce & ~flush & (state != S_HOLD_IF);
    stallreq_from_mem = mem_ce & (state != S_HOLD_MEM);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus_req <= ReqDisable;
      bus_we <= 1'b0;
      bus_sel <= '0;
      bus_addr <= '0;
      bus_wdata <= '0;
      if_rdata <= '0;
      if_err <= 1'b0;
      mem_rdata <= '0;
      mem_err <= 1'b0;
      discard <= 1'b0;
    end else begin
      if (start_mem | start_if) begin
        bus_req <= ReqEnable;
        bus_we <= start_mem & mem_we;
        bus_sel <= start_mem ? mem_sel : '1;
        bus_addr <= start_mem ? mem_addr : if_addr;
        bus_wdata <= start_mem ? mem_wdata : '0;
      end else if (done) bus_req <= ReqDisable;
      if (if_cap) begin
        if_rdata <= rd;
        if_err <= expired;
      end else if ((state == S_HOLD_IF) && (state_nx == S_IDLE)) if_err <= 1'b0;
      if (mem_cap) begin
        mem_rdata <= rd;
        mem_err <= expired;
      end else if ((state == S_HOLD_MEM) && (state_nx == S_IDLE)) mem_err <= 1'b0;
      discard <= (state == S_BUS_IF) & (state_nx == S_BUS_IF) & disc;
    end
endmodule
